// File: rtl/usb_rx_decoder.sv
// ============================================================================
// Module   : usb_rx_decoder
// Purpose  : USB full-speed style receive front end: sync, NRZI, de-stuffing
// Revision : 1.0
// ============================================================================
`default_nettype none

module usb_rx_decoder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_PT    = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_plus,
   input  logic       d_minus,
   input  logic       receiving,
   output logic       d_edge,
   output logic       shift_enable,
   output logic       byte_received,
   output logic [7:0] rx_data,
   output logic       eop,
   output logic       stuff_error
);

   localparam logic [4:0] c_TIMER_LAST = 5'(CLKS_PER_BIT - 1);
   localparam logic [4:0] c_SAMPLE     = 5'(SAMPLE_PT);
   localparam logic [2:0] c_STUFF_MAX  = 3'd6;
   localparam logic [2:0] c_BIT_LAST   = 3'd7;

   logic       r_dp_s1;
   logic       r_dp_s2;
   logic       r_dm_s1;
   logic       r_dm_s2;
   logic       r_dp_prev;
   logic [4:0] r_timer;
   logic       r_last_dp;
   logic       r_eop;
   logic [2:0] r_stuff_cnt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_rx_data;
   logic       r_byte_done;
   logic       r_stuff_err;

   logic       w_edge;
   logic       w_sample;
   logic       w_se0;
   logic       w_bit;
   logic [7:0] w_shift_next;

   // D+ idles high (J), so its stages reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_dp_s1   <= 1'b1;
         r_dp_s2   <= 1'b1;
         r_dm_s1   <= 1'b0;
         r_dm_s2   <= 1'b0;
         r_dp_prev <= 1'b1;
      end else begin
         r_dp_s1   <= d_plus;
         r_dp_s2   <= r_dp_s1;
         r_dm_s1   <= d_minus;
         r_dm_s2   <= r_dm_s1;
         r_dp_prev <= r_dp_s2;
      end
   end

   assign w_edge       = r_dp_s2 ^ r_dp_prev;
   assign w_sample     = (r_timer == c_SAMPLE) && !w_edge;
   assign w_se0        = !r_dp_s2 && !r_dm_s2;
   assign w_bit        = (r_dp_s2 == r_last_dp);
   assign w_shift_next = {w_bit, r_shift[7:1]};

   // A line transition restarts the bit period so sampling tracks the sender.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_timer <= 5'd0;
      end else if (w_edge || (r_timer == c_TIMER_LAST)) begin
         r_timer <= 5'd0;
      end else begin
         r_timer <= r_timer + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_last_dp <= 1'b1;
         r_eop     <= 1'b0;
      end else if (w_sample) begin
         r_last_dp <= r_dp_s2;
         r_eop     <= w_se0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_stuff_cnt <= 3'd0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_rx_data   <= 8'h00;
         r_byte_done <= 1'b0;
         r_stuff_err <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         r_stuff_err <= 1'b0;
         if (!receiving) begin
            r_stuff_cnt <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
         end else if (w_sample && w_se0) begin
            r_stuff_cnt <= 3'd0;
         end else if (w_sample) begin
            if (r_stuff_cnt == c_STUFF_MAX) begin
               // Stuffed bit position: always dropped, a 1 here is a violation.
               r_stuff_cnt <= 3'd0;
               r_stuff_err <= w_bit;
            end else begin
               r_stuff_cnt <= w_bit ? (r_stuff_cnt + 3'd1) : 3'd0;
               r_shift     <= w_shift_next;
               if (r_bit_cnt == c_BIT_LAST) begin
                  r_bit_cnt   <= 3'd0;
                  r_rx_data   <= w_shift_next;
                  r_byte_done <= 1'b1;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
         end
      end
   end

   assign d_edge        = w_edge;
   assign shift_enable  = w_sample;
   assign byte_received = r_byte_done;
   assign rx_data       = r_rx_data;
   assign eop           = r_eop;
   assign stuff_error   = r_stuff_err;

endmodule

`default_nettype wire
